// File: rtl/grayscale_pkg.sv
// Shared definitions for the RGB565-to-grayscale custom instruction:
// default luma weights, result-format modes and gray-to-RGB565 packing.
package grayscale_pkg;

  localparam int unsigned DEFAULT_WEIGHT_R = 54;
  localparam int unsigned DEFAULT_WEIGHT_G = 183;
  localparam int unsigned DEFAULT_WEIGHT_B = 19;

  typedef enum logic [1:0] {
    MODE_SINGLE  = 2'd0,
    MODE_PAIR    = 2'd1,
    MODE_GRAY565 = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Replicate an 8-bit gray level into all three RGB565 channels.
  function automatic logic [15:0] gray_to_rgb565(input logic [7:0] g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

endpackage

// File: rtl/rgb565_gray_lane.sv
// One RGB565 pixel to 8-bit gray: channel expansion and weighted products
// are registered on load; the rounded sum is combinational from that register.
module rgb565_gray_lane
  import grayscale_pkg::*;
#(
  parameter int unsigned WEIGHT_R = DEFAULT_WEIGHT_R,
  parameter int unsigned WEIGHT_G = DEFAULT_WEIGHT_G,
  parameter int unsigned WEIGHT_B = DEFAULT_WEIGHT_B
) (
  input  logic        clock,
  input  logic        load,
  input  logic [15:0] pixel,
  output logic [7:0]  gray
);

  if (WEIGHT_R + WEIGHT_G + WEIGHT_B != 256) begin : g_weight_check
    $error("rgb565_gray_lane: WEIGHT_R + WEIGHT_G + WEIGHT_B must equal 256");
  end

  logic [7:0]  r8, g8, b8;
  logic [15:0] prod_r, prod_g, prod_b;
  logic [15:0] sum;

  assign r8 = {pixel[15:11], pixel[15:13]};
  assign g8 = {pixel[10:5],  pixel[10:9]};
  assign b8 = {pixel[4:0],   pixel[4:2]};

  // NOTE: pure datapath registers carry no reset; the valid bit in the top
  // level decides whether their contents ever reach the output.
  always_ff @(posedge clock) begin
    if (load) begin
      prod_r <= 16'(WEIGHT_R) * {8'd0, r8};
      prod_g <= 16'(WEIGHT_G) * {8'd0, g8};
      prod_b <= 16'(WEIGHT_B) * {8'd0, b8};
    end
  end

  // Weights sum to 256, so the rounded total peaks at 65408 and fits 16 bits.
  assign sum  = prod_r + prod_g + prod_b + 16'd128;
  assign gray = 8'(sum >> 8);

endmodule

// File: rtl/grayscale_pipe_ci.sv
// Two-lane pipelined RGB565-to-grayscale custom instruction. A call accepted
// in cycle T pulses done with its result in cycle T+2; result is 0 otherwise.
module grayscale_pipe_ci
  import grayscale_pkg::*;
#(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned WEIGHT_R = DEFAULT_WEIGHT_R,
  parameter int unsigned WEIGHT_G = DEFAULT_WEIGHT_G,
  parameter int unsigned WEIGHT_B = DEFAULT_WEIGHT_B
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  logic        accept;
  logic        s1_valid;
  mode_e       s1_mode;
  logic [7:0]  gray0, gray1;
  logic [31:0] next_result;
  logic        unused_value_b;

  assign accept         = start && (iseId == customInstructionId);
  assign unused_value_b = ^valueB[31:2];

  rgb565_gray_lane #(
    .WEIGHT_R (WEIGHT_R),
    .WEIGHT_G (WEIGHT_G),
    .WEIGHT_B (WEIGHT_B)
  ) u_lane0 (
    .clock (clock),
    .load  (accept),
    .pixel (valueA[15:0]),
    .gray  (gray0)
  );

  rgb565_gray_lane #(
    .WEIGHT_R (WEIGHT_R),
    .WEIGHT_G (WEIGHT_G),
    .WEIGHT_B (WEIGHT_B)
  ) u_lane1 (
    .clock (clock),
    .load  (accept),
    .pixel (valueA[31:16]),
    .gray  (gray1)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_SINGLE;
    end else begin
      s1_valid <= accept;
      if (accept) s1_mode <= mode_e'(valueB[1:0]);
    end
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    next_result = '0;
    case (s1_mode)
      MODE_SINGLE:  next_result = {24'd0, gray0};
      MODE_PAIR:    next_result = {16'd0, gray1, gray0};
      MODE_GRAY565: next_result = {gray_to_rgb565(gray1), gray_to_rgb565(gray0)};
      default:      next_result = '0;
    endcase
  end

  // Output gated by valid so result can be OR-combined with other CIs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done   <= s1_valid;
      result <= s1_valid ? next_result : '0;
    end
  end

endmodule

// File: tb/tb_grayscale_pipe_ci.sv
// Self-checking bench for grayscale_pipe_ci: directed literal sequences plus
// randomized traffic compared every cycle against a behavioural model.
module tb_grayscale_pipe_ci;

  localparam logic [7:0] CI_ID = 8'h5A;
  localparam int WR = 54;
  localparam int WG = 183;
  localparam int WB = 19;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  grayscale_pipe_ci #(
    .customInstructionId (CI_ID),
    .WEIGHT_R (WR),
    .WEIGHT_G (WG),
    .WEIGHT_B (WB)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .iseId  (iseId),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model straight from the channel/weight/mode rules.
  function automatic int ref_gray(input logic [15:0] p);
    int r, g, b, r8, g8, b8;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    return (WR * r8 + WG * g8 + WB * b8 + 128) / 256;
  endfunction

  function automatic int ref_565(input int g);
    return (g / 8) * 2048 + (g / 4) * 32 + (g / 8);
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    int g0, g1;
    g0 = ref_gray(a[15:0]);
    g1 = ref_gray(a[31:16]);
    case (b % 4)
      0:       return 32'(g0);
      1:       return 32'(g1 * 256 + g0);
      2:       return {16'(ref_565(g1)), 16'(ref_565(g0))};
      default: return 32'd0;
    endcase
  endfunction

  // Expected completions tagged with the clock edge after which they show.
  typedef struct {
    int          due;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;

  always @(negedge reset) exp_q.delete();

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (!reset) begin
        check("model_rst_done", {31'd0, done}, 32'd0);
        check("model_rst_result", result, 32'd0);
      end else begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          check("model_done", {31'd0, done}, 32'd1);
          check("model_result", result, e.res);
        end else begin
          check("model_idle_done", {31'd0, done}, 32'd0);
          check("model_idle_result", result, 32'd0);
        end
        if (start && iseId == CI_ID) exp_q.push_back('{due: cyc + 1, res: ref_result(valueA, valueB)});
      end
    end
  end

  // Directed sequences with hand-computed expectations.
  logic [31:0] sq_a[8];
  logic [31:0] sq_b[8];
  logic [31:0] sq_exp[8];
  logic [7:0]  sq_id[8];
  int          sq_n;

  task automatic set_call(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] id, input logic [31:0] exp);
    sq_a[i] = a; sq_b[i] = b; sq_id[i] = id; sq_exp[i] = exp;
  endtask

  task automatic run_seq(input string name);
    logic hit;
    for (int i = 0; i <= sq_n + 1; i++) begin
      @(negedge clock);
      if (i < sq_n) begin
        start = 1'b1; iseId = sq_id[i]; valueA = sq_a[i]; valueB = sq_b[i];
      end else begin
        start = 1'b0; iseId = CI_ID; valueA = $urandom; valueB = $urandom;
      end
      @(posedge clock);
      #1;
      if (i >= 1 && i <= sq_n) begin
        hit = (sq_id[i-1] == CI_ID);
        check({name, "_done"}, {31'd0, done}, {31'd0, hit});
        check({name, "_result"}, result, hit ? sq_exp[i-1] : 32'd0);
      end else begin
        check({name, "_edge_done"}, {31'd0, done}, 32'd0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; iseId = 8'd0; valueA = '0; valueB = '0;
    #1 reset = 1'b0;
    #1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    sq_n = 1; set_call(0, 32'h0000_FFFF, 32'hABCD_EF00, CI_ID, 32'h0000_00FF);
    run_seq("white");
    sq_n = 1; set_call(0, 32'h0000_F800, 32'h0000_0000, CI_ID, 32'h0000_0036);
    run_seq("red");
    sq_n = 1; set_call(0, 32'h07E0_001F, 32'h0000_0005, CI_ID, 32'h0000_B613);
    run_seq("pair");
    sq_n = 1; set_call(0, 32'hFFFF_0000, 32'h0000_0002, CI_ID, 32'hFFFF_0000);
    run_seq("gray565");
    sq_n = 1; set_call(0, 32'hFFFF_FFFF, 32'h0000_0003, CI_ID, 32'h0000_0000);
    run_seq("reserved");

    sq_n = 4;
    set_call(0, 32'h0000_FFFF, 32'h0, CI_ID, 32'h0000_00FF);
    set_call(1, 32'h0000_F800, 32'h0, CI_ID, 32'h0000_0036);
    set_call(2, 32'h0000_001F, 32'h0, CI_ID, 32'h0000_0013);
    set_call(3, 32'h0000_FFFF, 32'h0, 8'h00, 32'h0000_0000);
    run_seq("b2b");

    // Reset mid-flight: the in-flight call must vanish; a call in the first
    // cycle after release completes normally.
    @(negedge clock);
    start = 1'b1; iseId = CI_ID; valueA = 32'h0000_FFFF; valueB = 32'h0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result", result, 32'd0);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    check("flush_hold_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset = 1'b1; start = 1'b1; iseId = CI_ID; valueA = 32'h0000_F800; valueB = 32'h0;
    @(posedge clock);
    #1;
    check("flush_dropped_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    check("post_reset_done", {31'd0, done}, 32'd1);
    check("post_reset_result", result, 32'h0000_0036);
    @(posedge clock);
    #1;
    check("post_reset_pulse_end", {31'd0, done}, 32'd0);

    repeat (400) begin
      @(negedge clock);
      start  = ($urandom_range(0, 9) < 7);
      iseId  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : CI_ID;
      valueA = $urandom;
      valueB = $urandom;
    end
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("model_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
